// File: rtl/note_spawner_pkg.sv
// Shared definitions for the light-column note spawner: FSM encoding, density
// thresholds, column count and the LFSR feedback mask.
package note_spawner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam int unsigned NUM_COLS  = 4;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    localparam logic [4:0] THRESH_L0 = 5'd4;
    localparam logic [4:0] THRESH_L1 = 5'd8;
    localparam logic [4:0] THRESH_L2 = 5'd12;
    localparam logic [4:0] THRESH_L3 = 5'd16;

    function automatic logic [4:0] level_threshold(input logic [1:0] level);
        logic [4:0] t;
        case (level)
            2'd0:    t = THRESH_L0;
            2'd1:    t = THRESH_L1;
            2'd2:    t = THRESH_L2;
            default: t = THRESH_L3;
        endcase
        return t;
    endfunction

    function automatic logic [NUM_COLS-1:0] col_onehot(input logic [1:0] col);
        return 4'b0001 << col;
    endfunction

endpackage

// File: rtl/note_spawner_if.sv
// Controller-side bundle of the note spawner: song control in, light pulses and status out.
interface note_spawner_if;
    import note_spawner_pkg::*;

    // No back-pressure: start is a one-cycle request taken only when enable=1 and
    // the spawner is idle/done; step and bl are one-cycle registered strobes.
    logic                enable;
    logic                start;
    logic [1:0]          level;
    logic [7:0]          song_len;
    logic [NUM_COLS-1:0] bl;
    logic                step;
    logic [7:0]          note_count;
    logic                busy;
    logic                done;

    modport master (
        output enable, start, level, song_len,
        input  bl, step, note_count, busy, done
    );

    modport slave (
        input  enable, start, level, song_len,
        output bl, step, note_count, busy, done
    );

endinterface

// File: rtl/note_spawner_lfsr16.sv
// 16-bit Galois right-shift LFSR with a loadable seed; advances one shift per advance_i.
module lfsr16
    import note_spawner_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        advance_i,
    input  logic [15:0] seed_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;
    logic [15:0] seed_safe;

    // An all-zero state would lock up the register, so a zero seed becomes 1.
    assign seed_safe = (seed_i == 16'h0000) ? 16'h0001 : seed_i;

    always_comb begin
        state_d = state_q;
        if (advance_i) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? LFSR_MASK : 16'h0000);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= seed_safe;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/note_spawner.sv
// Note spawner: paces a step strobe and drops LFSR-chosen bottom-light pulses into
// four light columns for a song of bounded length, then drains the columns.
module note_spawner
    import note_spawner_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 8,
    parameter int unsigned GAP_MIN     = 1,
    parameter int unsigned DRAIN_STEPS = 5,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    note_spawner_if.slave   bus,
    output state_e          state_o,
    output logic [15:0]     lfsr_o
);

    state_e              state_q;
    logic [7:0]          tick_q;
    logic [2:0]          gap_q;
    logic [7:0]          len_q;
    logic [7:0]          cnt_q;
    logic [7:0]          drain_q;
    logic                step_q;
    logic [NUM_COLS-1:0] bl_q;
    logic [15:0]         lfsr;

    logic run_or_drain;
    logic wrap;
    logic gap_ok;
    logic spawn;
    logic accept;
    logic advance;

    assign run_or_drain = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign wrap         = bus.enable && run_or_drain && (tick_q == 8'(TICK_DIV - 1));
    // gap_q saturates at GAP_MIN, so reaching it is the same as ">= GAP_MIN".
    assign gap_ok       = (gap_q == 3'(GAP_MIN));
    assign spawn        = wrap && (state_q == ST_RUN) && gap_ok &&
                          ({1'b0, lfsr[3:0]} < level_threshold(bus.level));
    assign accept       = bus.enable && bus.start && !run_or_drain;
    assign advance      = wrap && (state_q == ST_RUN);

    lfsr16 u_lfsr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .advance_i (advance),
        .seed_i    (LFSR_SEED),
        .state_o   (lfsr)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            gap_q   <= 3'(GAP_MIN);
            len_q   <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            step_q  <= 1'b0;
            bl_q    <= '0;
        end else begin
            step_q <= wrap;
            bl_q   <= '0;
            if (accept) begin
                len_q   <= bus.song_len;
                cnt_q   <= '0;
                tick_q  <= '0;
                gap_q   <= 3'(GAP_MIN);
                drain_q <= '0;
                state_q <= (bus.song_len == 8'd0) ? ST_DRAIN : ST_RUN;
            end else if (bus.enable && run_or_drain) begin
                tick_q <= wrap ? 8'd0 : tick_q + 8'd1;
                if (wrap && state_q == ST_RUN) begin
                    if (spawn) begin
                        bl_q  <= col_onehot(lfsr[5:4]);
                        cnt_q <= cnt_q + 8'd1;
                        gap_q <= '0;
                        if (cnt_q + 8'd1 == len_q) begin
                            state_q <= ST_DRAIN;
                        end
                    end else if (!gap_ok) begin
                        gap_q <= gap_q + 3'd1;
                    end
                end else if (wrap) begin
                    if (drain_q == 8'(DRAIN_STEPS - 1)) begin
                        state_q <= ST_DONE;
                    end else begin
                        drain_q <= drain_q + 8'd1;
                    end
                end
            end
        end
    end

    assign bus.bl         = bl_q;
    assign bus.step       = step_q;
    assign bus.note_count = cnt_q;
    assign bus.busy       = run_or_drain;
    assign bus.done       = (state_q == ST_DONE);
    assign state_o        = state_q;
    assign lfsr_o         = lfsr;

endmodule

// File: doc/note_spawner.md
Name: note_spawner

Overview:
- Transmit end of the light-column protocol. It generates the bottom-light (BL) pulses that enter each of the four columns of bubbling light cells.
- A programmable step timer paces the pattern. A 16-bit LFSR picks note timing and column. Density, minimum gap and song length are bounded.
- Sits between the game controller (Start/Level/SongLen) and the bottom cell of each column. Its Step strobe is the advance enable for the column cells.

Parameters:
- TICK_DIV, 8, clock cycles per step (legal range 2..255).
- GAP_MIN, 1, minimum empty steps between two spawns (0..7).
- DRAIN_STEPS, 5, steps spent in DRAIN so the last note clears a 5-position column.
- LFSR_SEED, 16'hACE1, LFSR load value; a zero seed is forced to 16'h0001.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Enable  in  1  1 = run; 0 = freeze timer, LFSR, gap counter and FSM.
- Start  in  1  one-cycle request to begin a song.
- Level  in  2  density select.
- SongLen  in  8  notes per song; sampled when Start is accepted.
- BL  out  4  one-hot bottom-light pulses, one bit per column; registered.
- Step  out  1  one-cycle step strobe; registered.
- NoteCount  out  8  notes spawned in the current song.
- Busy  out  1  high in RUN or DRAIN.
- Done  out  1  high in DONE.

Behaviour:
- Reset (Reset=0, async): FSM=IDLE, BL=0, Step=0, NoteCount=0, Busy=0, Done=0, tick counter=0, gap counter=GAP_MIN (saturated), LFSR=seed, song length latch=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE or DONE + Start (Enable=1) -> RUN. Latch SongLen, clear NoteCount and tick counter, set gap counter to GAP_MIN. LFSR is not reseeded.
  - IDLE or DONE + Start with SongLen=0 -> DRAIN directly; no notes are spawned.
  - Start is ignored in RUN and DRAIN.
  - RUN -> DRAIN on the edge that makes NoteCount equal the latched length.
  - DRAIN -> DONE after DRAIN_STEPS Steps.
  - DONE holds until the next Start.
- Tick counter:
  - Counts 0..TICK_DIV-1 in RUN/DRAIN while Enable=1; frozen when Enable=0.
  - On the edge where the counter is TICK_DIV-1, it wraps to 0 and Step is registered high for exactly one cycle.
  - The first Step comes TICK_DIV cycles after the Start edge.
- Spawn decision, made on the same edge that sets Step, in RUN only:
  - Threshold T by Level: 0->4, 1->8, 2->12, 3->16.
  - Spawn when gap counter >= GAP_MIN and LFSR[3:0] < T.
  - Column = LFSR[5:4]. BL is registered as the one-hot of that column, aligned with Step, high for exactly that one cycle.
  - On spawn: NoteCount+1 and gap counter cleared to 0. Without a spawn, the gap counter increments, saturating at GAP_MIN.
  - LFSR advances one shift on that same edge, using the pre-shift value for the decision.
  - LFSR form: Galois right shift, mask 16'hB400; feedback bit = LSB.
- BL is never asserted outside RUN, and never more than one bit at a time.
- Simultaneous events:
  - Enable=0 during the wrap cycle: no Step and no spawn; the wrap is deferred until Enable returns.
  - Start while Enable=0: ignored.
- Reset mid-song: immediate return to the reset state; any BL or Step in flight is dropped.
- Widths: NoteCount is 8-bit and cannot overflow, because the RUN exit occurs at SongLen ≤ 255.

Decomposition:
- Shared game package holds:
  - FSM state encodings: IDLE=2'b00, RUN=2'b01, DRAIN=2'b10, DONE=2'b11.
  - Level-to-threshold constants.
  - Column count constant (4).
  - LFSR mask constant.
- One sub-module is natural: lfsr16. Ports: Clock, Reset, advance, seed in, 16-bit state out. It is reusable for the miss/penalty generator.

Test Plan:
- Reset: hold Reset=0 for 3 cycles mid-RUN -> all outputs 0, FSM IDLE, LFSR = 16'hACE1 immediately (async, not waiting for a clock edge).
- Full density: TICK_DIV=4, GAP_MIN=0, Level=3, SongLen=3, Start -> Step pulses every 4 cycles, first at cycle 4 after Start. BL one-hot on Steps 1-3, matching a reference-model LFSR[5:4]. Then DRAIN for 5 Steps, then Done=1 with NoteCount=3.
- Gap rule: Level=3, GAP_MIN=2 -> spawns only on every 3rd Step. BL=0 on the two Steps between spawns. Step still pulses.
- Pause: Enable=0 for 10 cycles during RUN -> tick counter, LFSR and NoteCount unchanged. Next Step arrives exactly (remaining count) cycles after Enable returns.
- Edge length: SongLen=0 -> RUN skipped, no BL pulses, Done after 5 Steps. Start during RUN with SongLen=9 -> ignored; the song still ends at the original SongLen.
- Density statistics: Level=0, GAP_MIN=0, SongLen=255 -> every BL pulse coincides with Step, and the spawn-per-Step ratio is within 0.25±0.05 against the model. Column-bit counts match the model exactly.
